// File: rtl/bcd_display_scan_pkg.sv
// Shared types and seven-segment glyph constants for the BCD display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_display_scan_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] bcd_digit_t;

    localparam seg7_t SEG7_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam seg7_t SEG7_DASH  = 7'h40;
    localparam seg7_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Valid/ready handshake carrying a packed BCD word into the display scanner.
interface bcd_display_scan_if #(
    parameter int DIGITS = 5
) ();

    logic [DIGITS*4-1:0] bcd_in;
    logic                bcd_valid;
    logic                bcd_ready;

    modport master (output bcd_in, output bcd_valid, input bcd_ready);
    modport slave  (input bcd_in, input bcd_valid, output bcd_ready);

endinterface

// File: rtl/bcd_display_scan_seg7.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal nibbles show a dash.
module bcd_display_scan_seg7
    import bcd_display_scan_pkg::*;
(
    input  bcd_digit_t nibble,
    output seg7_t      glyph,
    output logic       invalid
);

    always_comb begin
        invalid = (nibble > 4'd9);
        glyph   = SEG7_DASH;
        for (int i = 0; i < 10; i++) begin
            if (nibble == bcd_digit_t'(i)) glyph = SEG7_DIGIT[i];
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment driver with a double-buffered BCD word swapped only at frame
// boundaries, leading-zero blanking and a sticky flag for non-decimal nibbles.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int DIGITS         = 5,
    parameter int REFRESH_DIV    = 1000,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_display_scan_if.slave   bus,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_tick,
    output logic                err_sticky
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    logic [PRE_W-1:0]    presc_q;
    logic [IDX_W-1:0]    dig_idx_q;
    logic [DIGITS*4-1:0] active_q;
    logic [DIGITS*4-1:0] pending_q;
    logic                pending_full_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic                frame_tick_q;
    logic                err_q;

    logic                tc;
    logic                boundary;
    logic [DIGITS*4-1:0] upper;
    bcd_digit_t          cur_nibble;
    logic                blank;
    seg7_t               glyph;
    logic                invalid;
    seg7_t               seg_next;
    logic [DIGITS-1:0]   an_onehot;

    assign tc       = (presc_q == PRE_LAST);
    assign boundary = tc && (dig_idx_q == IDX_LAST);

    // Shifting the current digit down to bit 0 gives both the nibble and the
    // "this digit and everything above it is zero" test for blanking.
    assign upper      = active_q >> {dig_idx_q, 2'b00};
    assign cur_nibble = bcd_digit_t'(upper);
    assign blank      = BLANK_LZ && (dig_idx_q != '0) && (upper == '0);
    assign seg_next   = blank ? SEG7_BLANK : glyph;
    assign an_onehot  = DIGITS'(1) << dig_idx_q;

    bcd_display_scan_seg7 u_seg7 (
        .nibble  (cur_nibble),
        .glyph   (glyph),
        .invalid (invalid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q        <= '0;
            dig_idx_q      <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            seg_q          <= SEG_OFF;
            an_q           <= AN_OFF;
            frame_tick_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            presc_q <= tc ? '0 : presc_q + 1'b1;
            if (tc) dig_idx_q <= (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
            frame_tick_q <= boundary;

            // Swap needs a full buffer, accept needs an empty one, so they never collide.
            if (boundary && pending_full_q) begin
                active_q       <= pending_q;
                pending_full_q <= 1'b0;
            end else if (bus.bcd_valid && !pending_full_q) begin
                pending_q      <= bus.bcd_in;
                pending_full_q <= 1'b1;
            end

            seg_q <= seg_next ^ SEG_OFF;
            an_q  <= an_onehot ^ AN_OFF;
            if (invalid) err_q <= 1'b1;
        end
    end

    assign bus.bcd_ready = ~pending_full_q;
    assign seg           = seg_q;
    assign an            = an_q;
    assign frame_tick    = frame_tick_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized bench for bcd_display_scan: a frame-time arithmetic model predicts every output cycle by cycle.
module tb_bcd_display_scan;

    localparam int D     = 5;
    localparam int R     = 4;
    localparam int FRAME = D * R;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   seg;
    logic [D-1:0] an;
    logic         frame_tick;
    logic         err_sticky;

    bcd_display_scan_if #(.DIGITS(D)) bus ();

    bcd_display_scan #(
        .DIGITS(D), .REFRESH_DIV(R), .BLANK_LZ(1'b1),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: e counts edges since reset; digit lit by state after edge e is (e/R)%D,
    // frame boundaries fall on edges that are multiples of FRAME.
    int           e = 0;
    int           last_tick = -1;
    logic [19:0]  m_active = '0;
    logic [19:0]  m_pend = '0;
    bit           m_full = 1'b0;
    bit           m_err = 1'b0;
    logic [6:0]   seen [D];

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (n > 4'd9) return 7'h40;
        return tab[n];
    endfunction

    function automatic logic [6:0] expect_seg(input logic [19:0] act, input int dig);
        logic [19:0] sh;
        sh = act >> (4 * dig);
        if (dig > 0 && sh == 20'h0) return 7'h00;
        return glyph_of(sh[3:0]);
    endfunction

    task automatic step(input bit rst, input bit valid, input logic [19:0] data);
        logic [6:0]   exp_seg;
        logic [D-1:0] exp_an;
        logic [19:0]  sh;
        bit           acc;
        bit           bnd;
        int           dig;
        rst_n         = !rst;
        bus.bcd_valid = valid;
        bus.bcd_in    = data;
        acc           = valid && !m_full && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            e = 0; last_tick = -1;
            m_full = 0; m_active = '0; m_pend = '0; m_err = 0;
            exp_seg = '0; exp_an = '0; bnd = 0;
        end else begin
            dig     = (e / R) % D;
            exp_seg = expect_seg(m_active, dig);
            exp_an  = D'(1 << dig);
            sh      = m_active >> (4 * dig);
            if (sh[3:0] > 4'd9) m_err = 1;
            e++;
            bnd = (e % FRAME) == 0;
            if (bnd && m_full) begin
                m_active = m_pend;
                m_full   = 0;
            end else if (acc) begin
                m_pend = data;
                m_full = 1;
            end
            if (frame_tick) begin
                if (last_tick >= 0) chk("tick_period", e - last_tick, FRAME);
                last_tick = e;
            end
        end
        chk("seg", seg, exp_seg);
        chk("an", an, exp_an);
        chk("frame_tick", frame_tick, bnd);
        chk("err_sticky", err_sticky, m_err);
        chk("bcd_ready", bus.bcd_ready, !m_full);
        for (int i = 0; i < D; i++) if (an == D'(1 << i)) seen[i] = seg;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0);
    endtask

    task automatic send(input logic [19:0] v);
        bit done = 0;
        for (int k = 0; k < 2 * FRAME + 4 && !done; k++) begin
            done = bus.bcd_ready;
            step(0, 1, v);
        end
        chk("send_accepted", done, 1);
    endtask

    task automatic check_frame(input string tag, input logic [6:0] exp [D]);
        idle(FRAME + 2);
        for (int i = 0; i < D; i++) seen[i] = 7'h7F;
        idle(FRAME);
        for (int i = 0; i < D; i++) chk(tag, seen[i], exp[i]);
    endtask

    function automatic logic [19:0] rand_word();
        logic [19:0] w = '0;
        int k = $urandom_range(0, D);
        for (int i = 0; i < k; i++) begin
            w[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    initial begin
        logic [6:0] exp_f [D];
        bus.bcd_valid = 1'b0;
        bus.bcd_in    = '0;

        repeat (3) step(1, 0, '0);
        idle(FRAME * 2);

        send(20'h00123);
        exp_f = '{7'h4F, 7'h5B, 7'h06, 7'h00, 7'h00};
        check_frame("frame_00123", exp_f);

        send(20'h00000);
        exp_f = '{7'h3F, 7'h00, 7'h00, 7'h00, 7'h00};
        check_frame("frame_00000", exp_f);

        send(20'h10005);
        exp_f = '{7'h6D, 7'h3F, 7'h3F, 7'h3F, 7'h06};
        check_frame("frame_10005", exp_f);

        send(20'h00001);
        chk("ready_low_after_a", bus.bcd_ready, 1'b0);
        send(20'h00002);
        idle(3 * FRAME);

        send(20'h000A5);
        exp_f = '{7'h6D, 7'h40, 7'h00, 7'h00, 7'h00};
        check_frame("frame_000a5", exp_f);
        send(20'h00001);
        idle(2 * FRAME + 2);
        chk("err_held", err_sticky, 1'b1);

        send(20'h00777);
        send(20'h00888);
        for (int k = 0; k < FRAME && ((e / R) % D) != 2; k++) idle(1);
        step(1, 0, '0);
        chk("rst_ready", bus.bcd_ready, 1'b1);
        idle(3 * FRAME);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) step(1, 0, '0);
            else if ($urandom_range(0, 24) == 0) send(rand_word());
            else idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
